solver_arbiter: RTL

Shares a single yankeeSolver polynomial unit (y = a·x² + b·x + c) between N_REQ independent requesters. A round-robin arbiter grants one request at a time, and an FSM then sequences the solver handshake: operand load, one-cycle enable pulse, wait for the valid rising edge, then wait for ready. Each result is routed back to its requester with an ID tag. A watchdog aborts a solver that never asserts valid.

---
 rtl/solver_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/solver_arbiter.sv
// solver_arbiter: round-robin sharing of one polynomial solver among N_REQ requesters,
// with operand load, enable pulse, valid-edge capture, watchdog abort and ID-tagged response.
module solver_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [8*N_REQ-1:0]    req_x_i,
    input  logic [16*N_REQ-1:0]   req_a_i,
    input  logic [16*N_REQ-1:0]   req_b_i,
    input  logic [16*N_REQ-1:0]   req_c_i,
    output logic [N_REQ-1:0]      req_ack_o,
    output logic                  resp_valid_o,
    output logic [ID_W-1:0]       resp_id_o,
    output logic [15:0]           resp_y_o,
    output logic                  resp_err_o,
    output logic [7:0]            slv_x_o,
    output logic [15:0]           slv_a_o,
    output logic [15:0]           slv_b_o,
    output logic [15:0]           slv_c_o,
    output logic                  slv_enable_o,
    input  logic [15:0]           slv_y_i,
    input  logic                  slv_ready_i,
    input  logic                  slv_valid_i,
    output logic                  busy_o
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_VALID, RESPOND, WAIT_READY} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, win, off;
    logic [ID_W:0]   sum, inc;
    logic [N_REQ-1:0] rot;
    logic [7:0]      x_q, x_d, sel_x;
    logic [15:0]     a_q, a_d, b_q, b_d, c_q, c_d, y_q, y_d, sel_a, sel_b, sel_c;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d, vprev_q, grant, rise, tmo;

    assign grant = |req_valid_i && slv_ready_i;
    assign rise  = slv_valid_i && !vprev_q;
    assign tmo   = cnt_q == CW'(TIMEOUT - 1);
    assign inc   = {1'b0, id_q} + 1'b1;

    // rotate so the scan starts at bit 0, then undo the rotation on the found offset
    always_comb begin
        rot = (req_valid_i >> rr_q) | (req_valid_i << (N_REQ - int'(rr_q)));
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = ID_W'(i);
        sum = {1'b0, rr_q} + {1'b0, off};
        win = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
    end

    always_comb begin
        sel_x = '0;
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_x = req_x_i[8*i +: 8];
                sel_a = req_a_i[16*i +: 16];
                sel_b = req_b_i[16*i +: 16];
                sel_c = req_c_i[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            x_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            vprev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            y_q     <= y_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            vprev_q <= slv_valid_i;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        y_d     = y_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                id_d    = win;
                x_d     = sel_x;
                a_d     = sel_a;
                b_d     = sel_b;
                c_d     = sel_c;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_VALID;
            end
            WAIT_VALID: begin
                cnt_d = cnt_q + 1'b1;
                if (rise) begin
                    y_d     = slv_y_i;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end else if (tmo) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                rr_d    = (inc == (ID_W+1)'(N_REQ)) ? '0 : inc[ID_W-1:0];
                state_d = WAIT_READY;
            end
            WAIT_READY: state_d = slv_ready_i ? IDLE : WAIT_READY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ack_o    = (rst_ni && state_q == IDLE && grant) ? N_REQ'(1) << win : '0;
        slv_enable_o = state_q == ISSUE;
        resp_valid_o = state_q == RESPOND;
        busy_o       = state_q != IDLE;
    end

    assign resp_id_o  = id_q;
    assign resp_y_o   = y_q;
    assign resp_err_o = err_q;
    assign slv_x_o    = x_q;
    assign slv_a_o    = a_q;
    assign slv_b_o    = b_q;
    assign slv_c_o    = c_q;

endmodule
